// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction fetch front end with a 2-entry decode queue.
// Issues one imem read per cycle while the queue has room. Read data comes
// back one cycle after the request. Each response is queued with the PC
// that fetched it.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN. When it is defined, a
// fetch from a PC that is not word aligned is flagged on id_excp, and its
// instruction is replaced with a nop (32'h0000_0013).
module if_fetch_queue (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   output logic        pc_en,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst,
   output logic        id_excp
);

   logic [31:0] q_pc   [2];
   logic [31:0] q_inst [2];
   logic [1:0]  count;
   logic        wptr;
   logic        rptr;
   logic        inflight;
   logic        inflight_kill;
   logic [31:0] inflight_pc;

   logic        pop;
   logic        push;
   logic        push_excp;
   logic [31:0] push_inst;
   logic [2:0]  occupancy;

   assign id_valid  = (count != 2'd0) & ~rst;
   assign pop       = id_valid & id_ready;
   assign imem_addr = pc;

   // Count the queued entries plus the one in flight, less the entry that
   // decode takes this cycle. A new request is issued only if the result
   // is below the depth, so the queue cannot overflow.
   always_comb begin
      occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
      imem_req  = (occupancy < 3'd2) & ~flush & ~rst;
      pc_en     = imem_req | (flush & ~rst);
      push      = inflight & ~inflight_kill & ~flush;
   end

`ifdef FETCH_MISALIGN_CHECK_EN
   logic [1:0] q_excp;

   assign push_excp = (inflight_pc[1:0] != 2'b00);
   assign push_inst = push_excp ? 32'h0000_0013 : imem_rdata;
   assign id_excp   = id_valid & q_excp[rptr];

   // Misalignment flag storage; it is written together with the data entry.
   always_ff @(posedge clk) begin
      if (push && !rst)
         q_excp[wptr] <= push_excp;
   end
`else
   assign push_excp = 1'b0;
   assign push_inst = imem_rdata;
   assign id_excp   = push_excp;
`endif

   assign id_pc   = id_valid ? q_pc[rptr]   : 32'h0;
   assign id_inst = id_valid ? q_inst[rptr] : 32'h0;

   // Track the outstanding read. A flush while it is in flight marks it
   // as killed.
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight      <= 1'b0;
         inflight_kill <= 1'b0;
         inflight_pc   <= 32'h0;
      end else if (imem_req) begin
         inflight      <= 1'b1;
         inflight_kill <= 1'b0;
         inflight_pc   <= pc;
      end else begin
         inflight      <= 1'b0;
         inflight_kill <= flush & inflight;
      end
   end

   // Queue occupancy and pointers. A flush empties the queue and overrides
   // any pop in the same cycle.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         count <= 2'd0;
         wptr  <= 1'b0;
         rptr  <= 1'b0;
      end else begin
         if (push)
            wptr <= ~wptr;
         if (pop)
            rptr <= ~rptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   // Entry storage. It has no reset because entries are only read while
   // count shows they are valid.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         q_pc[wptr]   <= inflight_pc;
         q_inst[wptr] <= push_inst;
      end
   end

   // The request credit makes a push into a full queue without a pop
   // impossible.
   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && count == 2'd2 && !pop));

endmodule

// File: tb/tb_if_fetch_queue.sv
// Testbench for if_fetch_queue. Per-cycle control expectations come from a
// vector table. A scoreboard queue holds the expected {pc, inst, excp} for
// every issued request and checks the head entry presented to decode.
module tb_if_fetch_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        id_ready = 1'b1;
   logic [31:0] tgt = 32'h0040_0000;
   logic [31:0] pc = 32'h0;
   logic        pc_en;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = 32'h0;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_inst;
   logic        id_excp;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        excp;
   } exp_t;

   typedef struct {
      logic        rst;
      logic        flush;
      logic        rdy;
      logic [31:0] addr;
      logic        req;
      logic        pen;
      logic        val;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[$];

   if_fetch_queue dut (
      .clk        (clk),
      .rst        (rst),
      .pc         (pc),
      .pc_en      (pc_en),
      .flush      (flush),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .id_valid   (id_valid),
      .id_ready   (id_ready),
      .id_pc      (id_pc),
      .id_inst    (id_inst),
      .id_excp    (id_excp)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   function automatic exp_t expect_for(input logic [31:0] a);
      exp_t e;
      e.pc = a;
`ifdef FETCH_MISALIGN_CHECK_EN
      e.excp = (a[1:0] != 2'b00);
      e.inst = e.excp ? 32'h0000_0013 : word(a);
`else
      e.excp = 1'b0;
      e.inst = word(a);
`endif
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic f, input logic y, input logic [31:0] a,
                      input logic q, input logic p, input logic v);
      vec_t t;
      t.rst = r; t.flush = f; t.rdy = y; t.addr = a;
      t.req = q; t.pen = p; t.val = v;
      vecs.push_back(t);
   endtask

   // PC register: reset loads tgt, a flush loads tgt as the redirect target,
   // and any other pc_en cycle advances by 4.
   always @(posedge clk) begin
      if (rst)
         pc <= tgt;
      else if (pc_en)
         pc <= flush ? tgt : pc + 32'd4;
   end

   // Instruction memory with one cycle of read latency. Cycles without a
   // request return garbage, so a bogus push would show up.
   always @(posedge clk) begin
      imem_rdata <= imem_req ? word(imem_addr) : 32'hDEAD_BEEF;
   end

   // Scoreboard: check the head entry, pop it on accepted handshakes,
   // drop everything on flush or reset, and record each new request.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         chk("imem_addr", imem_addr, pc);
         if (id_valid) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected_entry", id_pc, 32'hFFFF_FFFF);
            end else begin
               chk("head_pc", id_pc, sb[0].pc);
               chk("head_inst", id_inst, sb[0].inst);
               chk("head_excp", {31'b0, id_excp}, {31'b0, sb[0].excp});
               if (id_ready && !flush)
                  void'(sb.pop_front());
            end
         end else begin
            chk("idle_pc", id_pc, 32'h0);
            chk("idle_inst", id_inst, 32'h0);
            chk("idle_excp", {31'b0, id_excp}, 32'h0);
         end
         if (flush)
            sb.delete();
         if (imem_req)
            sb.push_back(expect_for(imem_addr));
      end
   end

   initial begin
      bit found;
      exp_t me;

      // rst flush rdy addr          req pen val
      add(1, 0, 1, 32'h0040_0000, 0, 0, 0);
      add(1, 0, 1, 32'h0040_0000, 0, 0, 0);
      add(0, 0, 1, 32'h0,         1, 1, 0);   // first request right after reset
      add(0, 0, 1, 32'h0,         1, 1, 0);
      for (int i = 0; i < 3; i++) add(0, 0, 1, 32'h0, 1, 1, 1);   // one per cycle
      for (int i = 0; i < 6; i++) add(0, 0, 0, 32'h0, 0, 0, 1);   // decode stall
      add(0, 0, 1, 32'h0,         1, 1, 1);   // drain resumes
      add(0, 0, 1, 32'h0,         1, 1, 1);
      add(0, 1, 1, 32'h0040_0100, 0, 1, 1);   // flush with an entry queued
      add(0, 0, 1, 32'h0,         1, 1, 0);
      add(0, 0, 1, 32'h0,         1, 1, 0);
      add(0, 0, 1, 32'h0,         1, 1, 1);
      add(0, 1, 1, 32'h0040_0200, 0, 1, 1);   // back-to-back flushes
      add(0, 1, 1, 32'h0040_0300, 0, 1, 0);
      add(0, 1, 1, 32'h0040_0400, 0, 1, 0);
      add(0, 0, 1, 32'h0,         1, 1, 0);
      add(0, 0, 1, 32'h0,         1, 1, 0);
      add(0, 0, 1, 32'h0,         1, 1, 1);
      add(0, 0, 0, 32'h0,         0, 0, 1);   // fill to 2
      add(0, 0, 0, 32'h0,         0, 0, 1);
      add(0, 1, 0, 32'h0040_0800, 0, 1, 1);   // flush while full
      add(0, 0, 0, 32'h0,         1, 1, 0);   // fill from empty: exactly 2 requests
      add(0, 0, 0, 32'h0,         1, 1, 0);
      for (int i = 0; i < 3; i++) add(0, 0, 0, 32'h0, 0, 0, 1);
      add(1, 0, 0, 32'h0050_0000, 0, 0, 0);   // reset while full
      add(0, 0, 1, 32'h0,         1, 1, 0);
      add(0, 0, 1, 32'h0,         1, 1, 0);
      for (int i = 0; i < 10; i++) add(0, 0, 1, 32'h0, 1, 1, 1);  // push+pop at count 1

      for (int i = 0; i < vecs.size(); i++) begin
         rst      = vecs[i].rst;
         flush    = vecs[i].flush;
         id_ready = vecs[i].rdy;
         tgt      = vecs[i].addr;
         @(negedge clk);
         chk($sformatf("v%0d imem_req", i), {31'b0, imem_req}, {31'b0, vecs[i].req});
         chk($sformatf("v%0d pc_en", i),    {31'b0, pc_en},    {31'b0, vecs[i].pen});
         chk($sformatf("v%0d id_valid", i), {31'b0, id_valid}, {31'b0, vecs[i].val});
         @(posedge clk);
         #1;
      end

      // Misaligned fetch: the expected flag and instruction depend on the
      // build option.
      rst = 1'b1; flush = 1'b0; id_ready = 1'b1; tgt = 32'h0040_0002;
      @(posedge clk);
      #1;
      rst = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 6 && !found; i++) begin
         @(negedge clk);
         if (id_valid) found = 1'b1;
      end
      if (!found) begin
         chk("misalign_timeout", 32'h0, 32'h1);
      end else begin
         me.pc = 32'h0040_0002;
`ifdef FETCH_MISALIGN_CHECK_EN
         me.excp = 1'b1;
         me.inst = 32'h0000_0013;
`else
         me.excp = 1'b0;
         me.inst = word(32'h0040_0002);
`endif
         chk("misalign_pc", id_pc, me.pc);
         chk("misalign_excp", {31'b0, id_excp}, {31'b0, me.excp});
         chk("misalign_inst", id_inst, me.inst);
      end
      repeat (3) @(posedge clk);
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
